// File: rtl/int_ctrl.sv
// Three-source nested interrupt controller with a priority level gate and a
// 3-deep return-address stack. Accept and return complete on the same edge.
module int_ctrl #(
  parameter logic [31:0] VEC0 = 32'h0000_0100,
  parameter logic [31:0] VEC1 = 32'h0000_0180,
  parameter logic [31:0] VEC2 = 32'h0000_0200
) (
  input  logic        clk,
  input  logic        CLR_N,
  input  logic [2:0]  IRQ,
  input  logic [2:0]  IRQ_MASK,
  input  logic [31:0] PC_next,
  input  logic        PC_EN,
  input  logic        ERET,
  output logic        Int,
  output logic [31:0] Iaddr,
  output logic [31:0] EPC,
  output logic [2:0]  InService,
  output logic [2:0]  Pending
);

  logic [2:0]  irq_q, irq_edge, gate, elig, sel, top_bit;
  logic [1:0]  sp;
  logic [31:0] stack [3];
  logic        accept, pop;

  assign irq_edge = IRQ & ~irq_q;

  // Only sources strictly above the deepest active level may nest.
  always_comb begin
    gate    = 3'b111;
    top_bit = 3'b000;
    if (InService[2]) begin
      gate    = 3'b000;
      top_bit = 3'b100;
    end else if (InService[1]) begin
      gate    = 3'b100;
      top_bit = 3'b010;
    end else if (InService[0]) begin
      gate    = 3'b110;
      top_bit = 3'b001;
    end
  end

  assign elig = Pending & IRQ_MASK & gate;

  always_comb begin
    sel   = 3'b000;
    Iaddr = '0;
    if (elig[2]) begin
      sel   = 3'b100;
      Iaddr = VEC2;
    end else if (elig[1]) begin
      sel   = 3'b010;
      Iaddr = VEC1;
    end else if (elig[0]) begin
      sel   = 3'b001;
      Iaddr = VEC0;
    end
  end

  assign Int    = PC_EN & ~ERET & (|elig);
  assign accept = Int;
  assign pop    = ERET & PC_EN & (sp != 2'd0);

  always_comb begin
    case (sp)
      2'd1:    EPC = stack[0];
      2'd2:    EPC = stack[1];
      2'd3:    EPC = stack[2];
      default: EPC = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    irq_q <= IRQ;
    if (!CLR_N) begin
      Pending   <= '0;
      InService <= '0;
      sp        <= '0;
      for (int k = 0; k < 3; k++) stack[k] <= '0;
    end else begin
      // A fresh edge on the source being taken re-arms it (OR after clear).
      Pending <= (Pending & ~(accept ? sel : 3'b000)) | irq_edge;
      if (accept) begin
        InService <= InService | sel;
        sp        <= sp + 2'd1;
        for (int k = 0; k < 3; k++)
          if (sp == k[1:0]) stack[k] <= PC_next;
      end else if (pop) begin
        InService <= InService & ~top_bit;
        sp        <= sp - 2'd1;
      end
    end
  end

  // Nesting levels strictly increase, so a push onto a full stack cannot occur.
  always_ff @(posedge clk) begin
    if (CLR_N && accept) assert (sp != 2'd3);
  end

endmodule

// File: tb/tb_int_ctrl.sv
// Bench for int_ctrl: directed vector table, then random traffic against a
// queue-based behavioural model of pending requests and nested service.
module tb_int_ctrl;

  logic        clk = 1'b0;
  logic        CLR_N, PC_EN, ERET;
  logic [2:0]  IRQ, IRQ_MASK;
  logic [31:0] PC_next;
  logic        Int;
  logic [31:0] Iaddr, EPC;
  logic [2:0]  InService, Pending;

  int checks = 0;
  int failures = 0;

  int_ctrl dut (
    .clk(clk), .CLR_N(CLR_N), .IRQ(IRQ), .IRQ_MASK(IRQ_MASK),
    .PC_next(PC_next), .PC_EN(PC_EN), .ERET(ERET),
    .Int(Int), .Iaddr(Iaddr), .EPC(EPC), .InService(InService), .Pending(Pending)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        clr_n;
    logic [2:0]  irq;
    logic [2:0]  mask;
    logic [31:0] pc;
    logic        en;
    logic        eret;
    logic        x_int;
    logic [31:0] x_iaddr;
    logic [31:0] x_epc;
    logic [2:0]  x_insv;
    logic [2:0]  x_pend;
  } vec_t;

  vec_t tbl[$];

  // Reference model: pending bits plus a stack of (source, return address).
  bit [2:0]    m_pend, m_irqq;
  int          m_src[$];
  logic [31:0] m_ret[$];
  logic        e_int;
  logic [31:0] e_iaddr, e_epc;
  logic [2:0]  e_insv;
  int          m_best;

  function automatic logic [31:0] vec_of(input int s);
    return (s == 2) ? 32'h200 : (s == 1) ? 32'h180 : 32'h100;
  endfunction

  function automatic void m_eval();
    int top;
    top    = (m_src.size() > 0) ? m_src[m_src.size()-1] : -1;
    m_best = -1;
    for (int i = 0; i < 3; i++)
      if (m_pend[i] && IRQ_MASK[i] && i > top) m_best = i;
    e_int   = PC_EN && !ERET && (m_best >= 0);
    e_iaddr = (m_best < 0) ? 32'h0 : vec_of(m_best);
    e_epc   = (m_ret.size() > 0) ? m_ret[m_ret.size()-1] : 32'h0;
    e_insv  = '0;
    foreach (m_src[k]) e_insv[m_src[k]] = 1'b1;
  endfunction

  function automatic void m_step();
    bit [2:0] edges;
    edges = IRQ & ~m_irqq;
    m_irqq = IRQ;
    if (!CLR_N) begin
      m_pend = '0;
      m_src.delete();
      m_ret.delete();
      return;
    end
    if (e_int) begin
      m_src.push_back(m_best);
      m_ret.push_back(PC_next);
      m_pend[m_best] = 1'b0;
    end else if (ERET && PC_EN && m_src.size() > 0) begin
      void'(m_src.pop_back());
      void'(m_ret.pop_back());
    end
    m_pend = m_pend | edges;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic c, input logic [2:0] irq, input logic [2:0] mask,
                       input logic [31:0] pc, input logic en, input logic er);
    @(negedge clk);
    CLR_N = c; IRQ = irq; IRQ_MASK = mask; PC_next = pc; PC_EN = en; ERET = er;
    #1;
    m_eval();
  endtask

  task automatic edge_step();
    @(posedge clk);
    m_step();
  endtask

  function automatic void add(input logic c, input logic [2:0] irq, input logic [2:0] mask,
                              input logic [31:0] pc, input logic en, input logic er,
                              input logic xi, input logic [31:0] xa, input logic [31:0] xe,
                              input logic [2:0] xs, input logic [2:0] xp);
    vec_t v;
    v = '{c, irq, mask, pc, en, er, xi, xa, xe, xs, xp};
    tbl.push_back(v);
  endfunction

  initial begin
    // Each row: inputs applied before an edge, outputs expected before that edge.
    add(0, 3'b000, 3'b111, 32'h00, 1, 0,  0, 32'h000, 32'h000, 3'b000, 3'b000); // reset state
    add(1, 3'b001, 3'b111, 32'h00, 1, 0,  0, 32'h000, 32'h000, 3'b000, 3'b000);
    add(1, 3'b001, 3'b111, 32'h40, 1, 0,  1, 32'h100, 32'h000, 3'b000, 3'b001); // basic take
    add(1, 3'b000, 3'b111, 32'h44, 1, 0,  0, 32'h000, 32'h040, 3'b001, 3'b000);
    add(1, 3'b100, 3'b111, 32'h105, 1, 0, 0, 32'h000, 32'h040, 3'b001, 3'b000);
    add(1, 3'b100, 3'b111, 32'h105, 1, 0, 1, 32'h200, 32'h040, 3'b001, 3'b100); // nest
    add(1, 3'b000, 3'b111, 32'h108, 1, 0, 0, 32'h000, 32'h105, 3'b101, 3'b000);
    add(1, 3'b010, 3'b111, 32'h200, 1, 0, 0, 32'h000, 32'h105, 3'b101, 3'b000);
    add(1, 3'b000, 3'b111, 32'h204, 1, 0, 0, 32'h000, 32'h105, 3'b101, 3'b010); // blocked
    add(1, 3'b000, 3'b111, 32'h204, 1, 1, 0, 32'h000, 32'h105, 3'b101, 3'b010); // eret
    add(1, 3'b000, 3'b111, 32'h48, 1, 0,  1, 32'h180, 32'h040, 3'b001, 3'b010);
    add(1, 3'b100, 3'b111, 32'h50, 0, 0,  0, 32'h000, 32'h048, 3'b011, 3'b000); // stalled capture
    add(1, 3'b100, 3'b111, 32'h50, 0, 0,  0, 32'h200, 32'h048, 3'b011, 3'b100);
    add(1, 3'b100, 3'b111, 32'h50, 1, 1,  0, 32'h200, 32'h048, 3'b011, 3'b100); // eret wins
    add(1, 3'b100, 3'b111, 32'h60, 1, 0,  1, 32'h200, 32'h040, 3'b001, 3'b100);
    add(1, 3'b000, 3'b111, 32'h64, 1, 1,  0, 32'h000, 32'h060, 3'b101, 3'b000);
    add(1, 3'b000, 3'b111, 32'h64, 1, 1,  0, 32'h000, 32'h040, 3'b001, 3'b000);
    add(1, 3'b010, 3'b101, 32'h00, 1, 0,  0, 32'h000, 32'h000, 3'b000, 3'b000); // masked edge
    add(1, 3'b000, 3'b101, 32'h00, 1, 0,  0, 32'h000, 32'h000, 3'b000, 3'b010);
    add(1, 3'b000, 3'b101, 32'h00, 1, 1,  0, 32'h000, 32'h000, 3'b000, 3'b010); // empty eret
    add(1, 3'b000, 3'b111, 32'h70, 1, 0,  1, 32'h180, 32'h000, 3'b000, 3'b010); // unmask
    add(1, 3'b000, 3'b111, 32'h74, 1, 0,  0, 32'h000, 32'h070, 3'b010, 3'b000);
    add(0, 3'b100, 3'b111, 32'h00, 1, 0,  0, 32'h000, 32'h070, 3'b010, 3'b000); // reset mid-service
    add(0, 3'b100, 3'b111, 32'h00, 1, 0,  0, 32'h000, 32'h000, 3'b000, 3'b000);
    add(1, 3'b100, 3'b111, 32'h00, 1, 0,  0, 32'h000, 32'h000, 3'b000, 3'b000);
    add(1, 3'b100, 3'b111, 32'h00, 1, 1,  0, 32'h000, 32'h000, 3'b000, 3'b000); // no edge, eret no-op
    add(1, 3'b000, 3'b111, 32'h00, 1, 0,  0, 32'h000, 32'h000, 3'b000, 3'b000);
    add(1, 3'b001, 3'b111, 32'h00, 1, 0,  0, 32'h000, 32'h000, 3'b000, 3'b000);
    add(1, 3'b000, 3'b111, 32'h00, 0, 0,  0, 32'h100, 32'h000, 3'b000, 3'b001);
    add(1, 3'b001, 3'b111, 32'h80, 1, 0,  1, 32'h100, 32'h000, 3'b000, 3'b001); // edge + accept
    add(1, 3'b001, 3'b111, 32'h84, 1, 0,  0, 32'h000, 32'h080, 3'b001, 3'b001);

    drive(0, 3'b000, 3'b111, 32'h0, 1, 0);
    edge_step();
    drive(0, 3'b000, 3'b111, 32'h0, 1, 0);
    edge_step();

    foreach (tbl[i]) begin
      drive(tbl[i].clr_n, tbl[i].irq, tbl[i].mask, tbl[i].pc, tbl[i].en, tbl[i].eret);
      chk($sformatf("tbl%0d.Int", i), {31'b0, Int}, {31'b0, tbl[i].x_int});
      chk($sformatf("tbl%0d.Iaddr", i), Iaddr, tbl[i].x_iaddr);
      chk($sformatf("tbl%0d.EPC", i), EPC, tbl[i].x_epc);
      chk($sformatf("tbl%0d.InService", i), {29'b0, InService}, {29'b0, tbl[i].x_insv});
      chk($sformatf("tbl%0d.Pending", i), {29'b0, Pending}, {29'b0, tbl[i].x_pend});
      edge_step();
    end

    // Random phase; the model has tracked every edge so far and stays in step.
    for (int n = 0; n < 3000; n++) begin
      logic [2:0] irq_r;
      logic [2:0] mask_r;
      irq_r  = IRQ;
      for (int b = 0; b < 3; b++)
        if ($urandom_range(3) == 0) irq_r[b] = ~irq_r[b];
      mask_r = ($urandom_range(9) == 0) ? 3'($urandom) : IRQ_MASK;
      drive(($urandom_range(99) != 0), irq_r, mask_r, $urandom,
            ($urandom_range(4) != 0), ($urandom_range(5) == 0));
      chk("rnd.Int", {31'b0, Int}, {31'b0, e_int});
      chk("rnd.Iaddr", Iaddr, e_iaddr);
      chk("rnd.EPC", EPC, e_epc);
      chk("rnd.InService", {29'b0, InService}, {29'b0, e_insv});
      chk("rnd.Pending", {29'b0, Pending}, {29'b0, m_pend});
      edge_step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/int_ctrl.md
INT_CTRL -- requirements
Module: int_ctrl

Interface
REQ-001 Parameter VEC0, default 32'h0000_0100, handler address for source 0 (lowest priority).
REQ-002 Parameter VEC1, default 32'h0000_0180, handler address for source 1.
REQ-003 Parameter VEC2, default 32'h0000_0200, handler address for source 2 (highest priority).
REQ-004 clk  in  1  single clock; all state updates on rising edge.
REQ-005 CLR_N  in  1  reset; synchronous, active-low.
REQ-006 IRQ  in  3  external request lines; rising edge raises a request.
REQ-007 IRQ_MASK  in  3  per-source enable; 1 = source may be taken.
REQ-008 PC_next  in  32  fetch-stage sequential next PC; serves as the return address.
REQ-009 PC_EN  in  1  fetch-stage PC update enable; 0 = stalled.
REQ-010 ERET  in  1  return-from-interrupt indication from decode.
REQ-011 Int  out  1  take-interrupt request to the fetch stage.
REQ-012 Iaddr  out  32  handler address; valid while Int=1.
REQ-013 EPC  out  32  return address for ERET; top of the return stack.
REQ-014 InService  out  3  one bit per source currently being serviced.
REQ-015 Pending  out  3  latched, not-yet-taken requests.

Function
REQ-016 irq_q SHALL register IRQ every cycle; edge = IRQ & ~irq_q.
REQ-017 An edge on source i SHALL set Pending[i]; a set bit stays 1 until taken, with no counting of repeated edges.
REQ-018 Level gate: source i is eligible only if Pending[i]=1, IRQ_MASK[i]=1, and i > index of highest InService bit (any i when InService=0).
REQ-019 Int SHALL be combinational: PC_EN=1, ERET=0, and at least one eligible source.
REQ-020 Iaddr SHALL be VEC of the highest-index eligible source, and 0 when none is eligible.
REQ-021 Accept, on an edge with Int=1: push PC_next onto the 3-entry return stack, set InService[i], clear Pending[i]; zero-latency, so the fetch stage loads Iaddr on the same edge.
REQ-022 If a new edge on source i coincides with accept of i, the set SHALL win: Pending[i] stays 1 and InService[i] is set.
REQ-023 EPC SHALL equal the top stack entry, and 0 when the stack is empty.
REQ-024 ERET=1 with PC_EN=1 and a non-empty stack SHALL pop the stack and clear the highest InService bit on the edge.
REQ-025 ERET with an empty stack SHALL cause no state change.
REQ-026 ERET=1 SHALL suppress Int for that cycle; an eligible request is taken on the next enabled cycle.
REQ-027 PC_EN=0: no accept and no pop; edge capture into Pending continues.
REQ-028 Stack depth 3 can never overflow because nesting levels strictly increase; a push when full is unreachable, and SHALL be a verification assertion.
REQ-029 IRQ_MASK changes SHALL affect eligibility immediately and SHALL NOT clear Pending.

Reset
REQ-030 CLR_N=0 at an edge SHALL clear Pending, InService, and all stack entries, and set stack pointer to 0.
REQ-031 During reset irq_q SHALL load IRQ, so a line held high through reset produces no edge after release.
REQ-032 After reset: Int=0, Iaddr=0, EPC=0, InService=0, Pending=0.
REQ-033 Reset mid-service SHALL discard the stack; a following ERET is a no-op.

Verification
REQ-034 Basic take: IRQ[0] 0->1, mask=3'b111, PC_EN=1, PC_next=32'h40.
-> Next cycle: Int=1, Iaddr=32'h100.
-> After the accept edge: EPC=32'h40, InService=3'b001, Pending=0.
REQ-035 Nesting: while serving source 0, pulse IRQ[2] with PC_next=32'h105.
-> Int=1, Iaddr=32'h200.
-> After accept: EPC=32'h105, InService=3'b101.
-> ERET: EPC=32'h40, InService=3'b001.
REQ-036 Blocking: while serving source 2, pulse IRQ[1].
-> Pending=3'b010, Int=0.
-> After ERET: Int=1, Iaddr=32'h180.
REQ-037 Stall and ERET priority: Pending[1]=1 with PC_EN=0.
-> Int=0, no state change.
-> PC_EN=1 with ERET=1: Int=0, pop occurs.
-> Next cycle: Int=1.
REQ-038 Mask and empty ERET: IRQ[1] edge with IRQ_MASK[1]=0.
-> Pending=3'b010, Int=0.
-> Unmask: Int=1 on the same cycle.
-> ERET with empty stack: EPC stays 0, no change.
REQ-039 Reset mid-service: CLR_N=0 with IRQ=3'b100 held high.
-> All outputs 0 after the edge.
-> After release: no Pending bit set.
